// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DefaultW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, try to subtract the divisor.
module div_step #(
  parameter int unsigned W = div_pkg::DefaultW
) (
  input  logic [W-1:0] rem_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  // The shifted partial remainder needs W+1 bits; the result always fits W since rem < divisor.
  logic [W:0] shifted;

  always_comb begin
    shifted = {rem_i, q_msb_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? (shifted[W-1:0] - divisor_i) : shifted[W-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned 2W/W restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int unsigned CntW = cnt_width(W);

  state_e          state_q, state_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    divisor_q, divisor_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_zero_q, div_zero_d;
  logic            overflow_q, overflow_d;

  logic [W-1:0]    step_rem;
  logic            step_q_bit;

  div_step #(
    .W (W)
  ) u_div_step (
    .rem_i     (rem_q),
    .q_msb_i   (q_q[W-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    q_d        = q_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          divisor_d = divisor;
          if (divisor == '0) begin
            state_d    = StDone;
            q_d        = '1;
            rem_d      = dividend[W-1:0];
            div_zero_d = 1'b1;
          end else if (dividend[2*W-1:W] >= divisor) begin
            state_d    = StDone;
            q_d        = '1;
            rem_d      = dividend[W-1:0];
            overflow_d = 1'b1;
          end else begin
            state_d = StRun;
            rem_d   = dividend[2*W-1:W];
            q_d     = dividend[W-1:0];
            cnt_d   = CntW'(W - 1);
          end
        end
      end
      StRun: begin
        // q doubles as the dividend low-half shift register; quotient bits enter at the LSB.
        rem_d = step_rem;
        q_d   = {q_q[W-2:0], step_q_bit};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d    = StIdle;
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      q_q        <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = q_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
